// File: rtl/input_index_queue_pp_pkg.sv
// -----------------------------------------------------------------------------
// input_index_queue_pp_pkg
// Shared definitions for the ping-pong input index queue:
//   INPUT_LAYER_NODES / QUEUE_MAX_SIZE : default frame size and bank depth
//   bank_state_t                        : per-bank life cycle encoding
//   count_width()                       : width of a 0..depth counter
// -----------------------------------------------------------------------------
package input_index_queue_pp_pkg;

    localparam int INPUT_LAYER_NODES = 784;
    localparam int QUEUE_MAX_SIZE    = 256;

    typedef enum logic [1:0] {
        BANK_EMPTY  = 2'd0,
        BANK_FILL   = 2'd1,
        BANK_SEALED = 2'd2,
        BANK_DRAIN  = 2'd3
    } bank_state_t;

    // A count must hold the value 'depth' itself (full bank), hence depth+1.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/input_index_queue_pp_bank.sv
// -----------------------------------------------------------------------------
// input_queue_bank
// One capture/drain bank: entry RAM, write count, read pointer, overflow bit
// and the EMPTY -> FILL -> SEALED -> DRAIN -> EMPTY state machine. All state
// changes are commanded by the top, which owns the cross-bank arbitration.
// Ports:
//   clk, resetN (async, active-low), flush (sync clear)
//   fill_go_i / seal_go_i / drain_go_i / free_go_i : state transition requests
//   wr_en_i, wr_data_i : append an entry (dropped and flagged when full)
//   rd_adv_i           : advance the read pointer
//   state_o, count_o, rd_ptr_o, rd_data_o (= entry[rd_ptr]), ovf_o
// -----------------------------------------------------------------------------
module input_queue_bank
    import input_index_queue_pp_pkg::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_MAX_SIZE,
    parameter int ENTRY_W     = 10,
    parameter int CW          = count_width(QUEUE_DEPTH)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               flush,
    input  logic               fill_go_i,
    input  logic               seal_go_i,
    input  logic               drain_go_i,
    input  logic               free_go_i,
    input  logic               wr_en_i,
    input  logic [ENTRY_W-1:0] wr_data_i,
    input  logic               rd_adv_i,
    output bank_state_t        state_o,
    output logic [CW-1:0]      count_o,
    output logic [CW-1:0]      rd_ptr_o,
    output logic [ENTRY_W-1:0] rd_data_o,
    output logic               ovf_o
);

    localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    bank_state_t        state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      rd_ptr_q, rd_ptr_d;
    logic               ovf_q, ovf_d;
    logic               full;
    logic [ENTRY_W-1:0] mem_q [QUEUE_DEPTH];

    assign full = (count_q == CW'(QUEUE_DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            // A one-pixel frame can seal straight out of EMPTY.
            BANK_EMPTY:  if (seal_go_i) state_d = BANK_SEALED;
                         else if (fill_go_i) state_d = BANK_FILL;
            BANK_FILL:   if (seal_go_i) state_d = BANK_SEALED;
            BANK_SEALED: if (drain_go_i) state_d = BANK_DRAIN;
            BANK_DRAIN:  if (free_go_i) state_d = BANK_EMPTY;
            default:     state_d = BANK_EMPTY;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (free_go_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_en_i) begin
                if (full) ovf_d = 1'b1;
                else      count_d = count_q + CW'(1);
            end
            if (rd_adv_i) rd_ptr_d = rd_ptr_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= BANK_EMPTY;
            count_q  <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else if (flush) begin
            state_q  <= BANK_EMPTY;
            count_q  <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry RAM has no reset; only slots below count_q are ever read out.
    always_ff @(posedge clk) begin
        if (resetN && !flush && wr_en_i && !full)
            mem_q[count_q[AW-1:0]] <= wr_data_i;
    end

    assign state_o   = state_q;
    assign count_o   = count_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/input_index_queue_pp.sv
// -----------------------------------------------------------------------------
// input_index_queue_pp
// Ping-pong input index queue. Scans a streamed frame of NUM_PIXELS pixels and
// queues the index of every pixel >= threshold into the capture bank while the
// other bank drains over valid/ready.
// Handshakes: a pixel moves when pixelValid & pixelReady at a rising edge; an
// entry moves when outValid & outReady at a rising edge. outIndex/outLast
// (and outValue) stay stable while outValid & !outReady.
// Ports:
//   clk, resetN (async, active-low), flush (sync clear, highest priority)
//   threshold, pixelValid, pixelValue, pixelReady : capture side
//   frameDone  : pulse after the last pixel of a frame is accepted
//   overflow   : active pixels of the frame being drained were dropped
//   outValid, outReady, outIndex, outLast, drainDone : drain side
//   outValue   : pixel value of the entry (only with IIQ_PIXEL_VALUE_EN)
//   bankState  : {bank1 state, bank0 state} for observation
// Build option: define IIQ_PIXEL_VALUE_EN to store pixel values per entry.
// -----------------------------------------------------------------------------
module input_index_queue_pp
    import input_index_queue_pp_pkg::*;
#(
    parameter int NUM_PIXELS  = INPUT_LAYER_NODES,
    parameter int QUEUE_DEPTH = QUEUE_MAX_SIZE,
    parameter int INDEX_WIDTH = 10,
    parameter int PIXEL_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   flush,
    input  logic [PIXEL_WIDTH-1:0] threshold,
    input  logic                   pixelValid,
    input  logic [PIXEL_WIDTH-1:0] pixelValue,
    output logic                   pixelReady,
    output logic                   frameDone,
    output logic                   overflow,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [INDEX_WIDTH-1:0] outIndex,
    output logic                   outLast,
    output logic                   drainDone,
`ifdef IIQ_PIXEL_VALUE_EN
    output logic [PIXEL_WIDTH-1:0] outValue,
`endif
    output logic [3:0]             bankState
);

    localparam int CW = count_width(QUEUE_DEPTH);
`ifdef IIQ_PIXEL_VALUE_EN
    localparam int EW = INDEX_WIDTH + PIXEL_WIDTH;
`else
    localparam int EW = INDEX_WIDTH;
`endif

    bank_state_t       st  [2];
    logic [CW-1:0]     cnt [2];
    logic [CW-1:0]     rdp [2];
    logic [EW-1:0]     rdd [2];
    logic [1:0]        ovf, fill_go, seal_go, drain_go, free_go, wr_en, rd_adv;

    logic [INDEX_WIDTH-1:0] pix_q, pix_d;
    logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;
    logic                   frame_done_q, frame_done_d, drain_done_q, drain_done_d;
    logic                   overflow_q, overflow_d;
    logic [PIXEL_WIDTH-1:0] out_value_q, out_value_d;

    logic          any_fill, any_empty, cap_sel, xfer_in, last_pix, active;
    logic          drain_any, dsel, out_xfer, done, entering, esel;
    logic          ld_en, ld_last;
    logic [EW-1:0] ld_entry, wr_data;

    // Capture goes to the FILL bank; with none in FILL an EMPTY bank takes the
    // pixel and becomes FILL on that edge, so a frame boundary costs no cycle.
    assign any_fill   = (st[0] == BANK_FILL) || (st[1] == BANK_FILL);
    assign any_empty  = (st[0] == BANK_EMPTY) || (st[1] == BANK_EMPTY);
    assign cap_sel    = (st[0] == BANK_FILL) ? 1'b0 :
                        (st[1] == BANK_FILL) ? 1'b1 :
                        (st[0] == BANK_EMPTY) ? 1'b0 : 1'b1;
    assign pixelReady = any_fill || any_empty;
    assign xfer_in    = pixelValid && pixelReady;
    assign last_pix   = (pix_q == INDEX_WIDTH'(NUM_PIXELS - 1));
    assign active     = (pixelValue >= threshold);

`ifdef IIQ_PIXEL_VALUE_EN
    assign wr_data = {pixelValue, pix_q};
`else
    assign wr_data = pix_q;
`endif

    // An empty frame sits in DRAIN for exactly one cycle; a non-empty one
    // leaves on the edge its outLast entry is taken.
    assign drain_any = (st[0] == BANK_DRAIN) || (st[1] == BANK_DRAIN);
    assign dsel      = (st[1] == BANK_DRAIN);
    assign out_xfer  = out_valid_q && outReady;
    assign done      = drain_any && ((cnt[dsel] == '0) || (out_xfer && out_last_q));
    assign entering  = |drain_go;
    assign esel      = drain_go[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        localparam logic ME = 1'(gi);
        bank_state_t other;
        assign other        = st[1-gi];
        assign fill_go[gi]  = pixelReady && (cap_sel == ME);
        assign seal_go[gi]  = xfer_in && last_pix && (cap_sel == ME);
        assign wr_en[gi]    = xfer_in && active && (cap_sel == ME);
        assign drain_go[gi] = (st[gi] == BANK_SEALED) &&
                              ((other == BANK_EMPTY) || ((other == BANK_DRAIN) && done));
        assign free_go[gi]  = (st[gi] == BANK_DRAIN) && done;
        assign rd_adv[gi]   = drain_go[gi] ||
                              ((st[gi] == BANK_DRAIN) && out_xfer && !out_last_q);

        input_queue_bank #(
            .QUEUE_DEPTH (QUEUE_DEPTH),
            .ENTRY_W     (EW),
            .CW          (CW)
        ) u_bank (
            .clk        (clk),
            .resetN     (resetN),
            .flush      (flush),
            .fill_go_i  (fill_go[gi]),
            .seal_go_i  (seal_go[gi]),
            .drain_go_i (drain_go[gi]),
            .free_go_i  (free_go[gi]),
            .wr_en_i    (wr_en[gi]),
            .wr_data_i  (wr_data),
            .rd_adv_i   (rd_adv[gi]),
            .state_o    (st[gi]),
            .count_o    (cnt[gi]),
            .rd_ptr_o   (rdp[gi]),
            .rd_data_o  (rdd[gi]),
            .ovf_o      (ovf[gi])
        );
    end

    always_comb begin
        pix_d        = pix_q;
        out_valid_d  = out_valid_q;
        out_index_d  = out_index_q;
        out_last_d   = out_last_q;
        out_value_d  = out_value_q;
        overflow_d   = overflow_q;
        frame_done_d = xfer_in && last_pix;
        drain_done_d = 1'b0;
        ld_en        = 1'b0;
        ld_entry     = rdd[dsel];
        ld_last      = (rdp[dsel] + CW'(1) == cnt[dsel]);

        if (xfer_in) pix_d = last_pix ? '0 : pix_q + INDEX_WIDTH'(1);

        if (out_xfer) begin
            if (out_last_q) begin
                out_valid_d  = 1'b0;
                out_last_d   = 1'b0;
                drain_done_d = 1'b1;
            end else begin
                ld_en = 1'b1;
            end
        end

        // A bank entering DRAIN presents entry 0 right away (read pointer is 0).
        if (entering) begin
            overflow_d = ovf[esel];
            if (cnt[esel] != '0) begin
                out_valid_d = 1'b1;
                ld_en       = 1'b1;
                ld_entry    = rdd[esel];
                ld_last     = (cnt[esel] == CW'(1));
            end else begin
                drain_done_d = 1'b1;
            end
        end

        if (ld_en) begin
            out_index_d = ld_entry[INDEX_WIDTH-1:0];
            out_last_d  = ld_last;
`ifdef IIQ_PIXEL_VALUE_EN
            out_value_d = ld_entry[EW-1:INDEX_WIDTH];
`endif
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN || flush) begin
            pix_q        <= '0;
            out_valid_q  <= 1'b0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            out_value_q  <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            pix_q        <= pix_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
            out_value_q  <= out_value_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign outValid  = out_valid_q;
    assign outIndex  = out_index_q;
    assign outLast   = out_last_q;
    assign overflow  = overflow_q;
    assign frameDone = frame_done_q;
    assign drainDone = drain_done_q;
    assign bankState = {st[1], st[0]};
`ifdef IIQ_PIXEL_VALUE_EN
    assign outValue  = out_value_q;
`else
    logic unused_value;
    assign unused_value = ^out_value_q;
`endif

endmodule
